dmem_wait: RTL and testbench

DMEM_WAIT -- requirements
Module: dmem_wait

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_wait_array.sv | 34 +++
 rtl/dmem_wait.sv | 121 ++++++++++++
 tb/tb_dmem_wait.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default parameters for the wait-state data memory.
package dmem_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_wait_array.sv
// Word-addressed storage with byte-strobe write; merged_o is the word as it
// will read after a strobed write of wdata_i, so callers get write-then-read data.
module dmem_wait_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    output logic [DATA_W-1:0]     merged_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        merged_o = mem[idx_i];
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (wstrb_i[b]) begin
                merged_o[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    // No reset: contents survive reset_n by design.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[idx_i] <= merged_o;
        end
    end

endmodule

// File: rtl/dmem_wait.sv
// Single-outstanding data memory with a fixed request-to-response latency.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
module dmem_wait
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output state_t              dbg_state_o
);

    if (LATENCY < 1 || DATA_W % 8 != 0) begin : g_bad_param
        $error("dmem_wait: LATENCY must be >= 1 and DATA_W a multiple of 8");
    end

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = (NB > 1) ? $clog2(NB) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFF_W) - 64'd1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic [31:0]         word_idx;
    logic                req_err;
    logic                accept;
    logic                wr_en;
    logic [DATA_W-1:0]   merged;

    assign word_idx = req_addr >> OFF_W;
    assign req_err  = (word_idx >= 32'(DEPTH)) || ((req_addr & OFF_MASK) != 32'd0);
    assign accept   = req_valid && req_ready_q;
    assign wr_en    = accept && !req_err && (req_wstrb != '0);

    dmem_wait_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk      (clk),
        .we_i     (wr_en),
        .idx_i    (word_idx[IDX_W-1:0]),
        .wdata_i  (req_wdata),
        .wstrb_i  (req_wstrb),
        .merged_o (merged)
    );

    // WAIT holds for LATENCY-1 cycles so rsp_valid is sampled high LATENCY edges after accept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        rdata_q     <= req_err ? '0 : merged;
                        err_q       <= req_err;
                        if (LATENCY == 1) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(LATENCY - 2);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_wait.sv
// Bench for dmem_wait: three instances (LATENCY 2, 1, 5) against a cycle-level
// reference model, plus hand-computed expectations for the directed scenarios.
module tb_dmem_wait;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wstrb [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    state_t      dbg_state [3];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
        dmem_wait #(.DATA_W(32), .DEPTH(256), .LATENCY(LAT)) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_addr    (req_addr[g]),
            .req_wdata   (req_wdata[g]),
            .req_wstrb   (req_wstrb[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_ready   (rsp_ready[g]),
            .rsp_rdata   (rsp_rdata[g]),
            .rsp_err     (rsp_err[g]),
            .dbg_state_o (dbg_state[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: memory contents, readiness, and the edge after which the
    // pending response becomes visible, all derived from the behavioural rules.
    logic [31:0] mm [3][256];
    logic        m_ready [3];
    logic        m_pend  [3];
    int          m_vis   [3];
    logic [31:0] m_rdata [3];
    logic        m_err   [3];

    task automatic model_accept(input int i);
        logic [31:0] idx;
        logic [31:0] word;
        logic        bad;
        idx  = req_addr[i] >> 2;
        bad  = (idx >= 32'd256) || (req_addr[i][1:0] != 2'b00);
        word = bad ? 32'd0 : mm[i][idx[7:0]];
        for (int b = 0; b < 4; b++)
            if (req_wstrb[i][b]) word[b*8 +: 8] = req_wdata[i][b*8 +: 8];
        if (!bad) mm[i][idx[7:0]] = word;
        m_rdata[i] = bad ? 32'd0 : word;
        m_err[i]   = bad;
        m_pend[i]  = 1'b1;
        m_ready[i] = 1'b0;
        m_vis[i]   = cyc + lat_of(i) - 1;
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                m_ready[i] = 1'b0;
                m_pend[i]  = 1'b0;
            end else if (m_pend[i]) begin
                if ((cyc - 1 >= m_vis[i]) && rsp_ready[i]) begin
                    m_pend[i]  = 1'b0;
                    m_ready[i] = 1'b1;
                end
            end else if (m_ready[i] && req_valid[i]) begin
                model_accept(i);
            end else begin
                m_ready[i] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 3; i++) begin
                logic exp_v;
                exp_v = m_pend[i] && (cyc >= m_vis[i]);
                check($sformatf("req_ready[%0d]", i), {31'd0, req_ready[i]}, {31'd0, m_ready[i]});
                check($sformatf("rsp_valid[%0d]", i), {31'd0, rsp_valid[i]}, {31'd0, exp_v});
                if (exp_v) begin
                    check($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i], m_rdata[i]);
                    check($sformatf("rsp_err[%0d]", i), {31'd0, rsp_err[i]}, {31'd0, m_err[i]});
                end
            end
        end
    end

    // One request/response on instance i; stall > 0 holds rsp_ready low that many
    // cycles while offering a stray write that must be ignored.
    task automatic do_req(input int i, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int stall,
                          output logic [31:0] rdata, output logic err, output int lat);
        int w;
        rdata = 32'd0;
        err   = 1'b0;
        lat   = 0;
        @(negedge clk);
        w = 0;
        while (!req_ready[i] && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid[i] = 1'b1;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_wstrb[i] = wstrb;
        @(negedge clk);
        req_valid[i] = 1'b0;
        lat = 1;
        while (!rsp_valid[i] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) begin
            check("rsp_valid_timeout", 32'd0, 32'd1);
            return;
        end
        rdata = rsp_rdata[i];
        err   = rsp_err[i];
        for (int s = 0; s < stall; s++) begin
            req_valid[i] = 1'b1;
            req_addr[i]  = 32'h10;
            req_wdata[i] = 32'hCAFEF00D;
            req_wstrb[i] = 4'hF;
            @(negedge clk);
        end
        req_valid[i] = 1'b0;
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        rsp_ready[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            req_wstrb[i] = 4'd0;
            rsp_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_req_ready", {31'd0, req_ready[i]}, 32'd0);
            check("rst_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
            check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
            check("rst_rsp_err",   {31'd0, rsp_err[i]}, 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, req_ready[0]}, 32'd1);

        // Write then read back, LATENCY=2
        do_req(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        check("wr10_rdata", rd, 32'hDEADBEEF);
        check("wr10_lat", lat, 32'd2);
        do_req(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("rd10_rdata", rd, 32'hDEADBEEF);
        check("rd10_err", {31'd0, er}, 32'd0);
        check("rd10_lat", lat, 32'd2);

        // Partial byte write merge
        do_req(0, 32'h4, 32'h11223344, 4'hF, 0, rd, er, lat);
        do_req(0, 32'h4, 32'h0000AA00, 4'h2, 0, rd, er, lat);
        check("strb_rdata", rd, 32'h1122AA44);
        check("strb_mem1", g_dut[0].u_dut.u_array.mem[1], 32'h1122AA44);

        // Out-of-range and misaligned accesses
        do_req(0, 32'h400, 32'h0, 4'h0, 0, rd, er, lat);
        check("oor_err", {31'd0, er}, 32'd1);
        check("oor_rdata", rd, 32'd0);
        do_req(0, 32'h6, 32'h0, 4'h0, 0, rd, er, lat);
        check("mis_err", {31'd0, er}, 32'd1);
        check("mis_rdata", rd, 32'd0);
        do_req(0, 32'h5, 32'h0, 4'hF, 0, rd, er, lat);
        check("miswr_err", {31'd0, er}, 32'd1);
        check("miswr_mem1", g_dut[0].u_dut.u_array.mem[1], 32'h1122AA44);

        // Response stall with a stray request offered throughout
        do_req(0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        check("stall_rdata", rd, 32'hDEADBEEF);
        check("stall_mem4", g_dut[0].u_dut.u_array.mem[4], 32'hDEADBEEF);
        do_req(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("post_stall_rdata", rd, 32'hDEADBEEF);

        // Latency extremes
        do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        check("l1_wr_lat", lat, 32'd1);
        do_req(1, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("l1_rd_rdata", rd, 32'hDEADBEEF);
        check("l1_rd_lat", lat, 32'd1);
        do_req(2, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        check("l5_wr_lat", lat, 32'd5);
        do_req(2, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("l5_rd_rdata", rd, 32'hDEADBEEF);
        check("l5_rd_lat", lat, 32'd5);

        // Reset while a write response is pending: write persists, response dropped
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h8;
        req_wdata[2] = 32'h12345678;
        req_wstrb[2] = 4'hF;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rstwait_rsp_valid", {31'd0, rsp_valid[2]}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rstwait_ready", {31'd0, req_ready[2]}, 32'd1);
        check("rstwait_no_rsp", {31'd0, rsp_valid[2]}, 32'd0);
        do_req(2, 32'h8, 32'h0, 4'h0, 0, rd, er, lat);
        check("rstwait_rdata", rd, 32'h12345678);
        check("rstwait_err", {31'd0, er}, 32'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
